// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: fill modes, FSM states and the default width.
// The fill-bit helper encodes what enters bit 0 of the register on every shift.
package shift_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_ONE    = 2'd1,
    MODE_SERIAL = 2'd2,
    MODE_ROTATE = 2'd3
  } fill_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic fill_bit(fill_mode_e mode, logic serial_bit, logic msb);
    logic bit_v;
    case (mode)
      MODE_ZERO:   bit_v = 1'b0;
      MODE_ONE:    bit_v = 1'b1;
      MODE_SERIAL: bit_v = serial_bit;
      MODE_ROTATE: bit_v = msb;
      default:     bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request and register-control bundle of the shift sequencer.
// The abort/aborted pair exists only when SHIFT_SEQUENCER_ABORT_EN is defined.
interface shift_sequencer_if #(
  parameter int WIDTH = shift_seq_pkg::DEFAULT_WIDTH
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] start_data;
  logic [CNT_W-1:0] start_count;
  logic [1:0]       start_mode;
  logic             serial_in;
  logic [WIDTH-1:0] reg_q;
  logic             ready;
  logic             busy;
  logic             done;
  logic             ser_req;
  logic             reg_load;
  logic [WIDTH-1:0] reg_load_data;
  logic             reg_shift;
  logic             reg_d0;
  logic [CNT_W-1:0] shifts_left;
`ifdef SHIFT_SEQUENCER_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  modport master (
    output start, start_data, start_count, start_mode, serial_in, reg_q,
`ifdef SHIFT_SEQUENCER_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  ready, busy, done, ser_req, reg_load, reg_load_data, reg_shift, reg_d0, shifts_left
  );

  modport slave (
    input  start, start_data, start_count, start_mode, serial_in, reg_q,
`ifdef SHIFT_SEQUENCER_ABORT_EN
    input  abort,
    output aborted,
`endif
    output ready, busy, done, ser_req, reg_load, reg_load_data, reg_shift, reg_d0, shifts_left
  );

endinterface

// File: rtl/shift_counter.sv
// Loadable down-counter for the remaining shifts; a load above WIDTH clamps to WIDTH.
// zero_o/one_o let the FSM decide its exit without its own compare logic.
module shift_counter
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o,
  output logic             one_o
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  // next count: clamped load, or decrement that saturates at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = (load_val_i > MAX_CNT) ? MAX_CNT : load_val_i;
    end else if (dec_i && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - ONE_CNT;
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == {CNT_W{1'b0}});
  assign one_o   = (count_q == ONE_CNT);

endmodule

// File: rtl/shift_sequencer.sv
// Sequences one left-shift register through load then N shifts, then pulses done.
// Optional abort path is enabled by defining SHIFT_SEQUENCER_ABORT_EN.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              reset,
  shift_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  fill_mode_e       mode_q;
  logic [WIDTH-1:0] load_data_q;
  logic             ready_q, busy_q, done_q, load_q, shift_q, ser_req_q;
  logic             accept_s, dec_s, abort_s, cnt_zero_s, cnt_one_s, d0_s;
  logic [CNT_W-1:0] cnt_s;
  logic             unused_s;

`ifdef SHIFT_SEQUENCER_ABORT_EN
  logic aborted_q;
  assign abort_s     = bus.abort;
  assign bus.aborted = aborted_q;
`else
  assign abort_s = 1'b0;
`endif

  shift_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept_s),
    .load_val_i (bus.start_count),
    .dec_i      (dec_s),
    .count_o    (cnt_s),
    .zero_o     (cnt_zero_s),
    .one_o      (cnt_one_s)
  );

  // next-state selection; abort outranks the normal LOAD/SHIFT exits
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    dec_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort_s)         state_d = ST_IDLE;
        else if (cnt_zero_s) state_d = ST_DONE;
        else                 state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        dec_s = 1'b1;
        if (abort_s)        state_d = ST_IDLE;
        else if (cnt_one_s) state_d = ST_DONE;
        else                state_d = ST_SHIFT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state plus registered output decodes of the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ZERO;
      load_data_q <= {WIDTH{1'b0}};
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
      shift_q     <= 1'b0;
      ser_req_q   <= 1'b0;
`ifdef SHIFT_SEQUENCER_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == ST_IDLE);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      load_q    <= (state_d == ST_LOAD);
      shift_q   <= (state_d == ST_SHIFT);
      ser_req_q <= (state_d == ST_SHIFT) && (mode_q == MODE_SERIAL);
      if (accept_s) begin
        load_data_q <= bus.start_data;
        mode_q      <= fill_mode_e'(bus.start_mode);
      end
`ifdef SHIFT_SEQUENCER_ABORT_EN
      aborted_q <= abort_s && ((state_q == ST_LOAD) || (state_q == ST_SHIFT));
`endif
    end
  end

  // D0 follows serial_in / register MSB combinationally while shifting
  always_comb begin
    d0_s = 1'b0;
    if (shift_q) begin
      d0_s = fill_bit(mode_q, bus.serial_in, bus.reg_q[WIDTH-1]);
    end else begin
      d0_s = 1'b0;
    end
  end

  assign unused_s          = ^bus.reg_q[WIDTH-2:0];
  assign bus.ready         = ready_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.ser_req       = ser_req_q;
  assign bus.reg_load      = load_q;
  assign bus.reg_load_data = load_data_q;
  assign bus.reg_shift     = shift_q;
  assign bus.reg_d0        = d0_s;
  assign bus.shifts_left   = cnt_s;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: stimulus pushes reference results, a negedge monitor pops them on done.
// Also models the shift register and the serial source that advances on ser_req.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  typedef struct {
    logic [W-1:0] res;
    int           done_cyc;
    int           cnt;
    int           mode;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  shift_sequencer_if #(.WIDTH(W)) bus();

  shift_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           shifts_seen = 0;
  int           ser_idx = 0;
  logic [63:0]  ser_bits = 64'd0;
  logic [W-1:0] regv = 8'h00;
  exp_t         sb[$];

  assign bus.serial_in = ser_bits[ser_idx[5:0]];
  assign bus.reg_q     = regv;

  always @(posedge clk) cyc <= cyc + 1;

  // the shifted register the sequencer controls
  always @(posedge clk) begin
    if (bus.reg_load)       regv <= bus.reg_load_data;
    else if (bus.reg_shift) regv <= {regv[W-2:0], bus.reg_d0};
  end

  // serial source: next bit presented just after an edge where ser_req was high
  initial begin
    logic adv;
    forever begin
      @(posedge clk);
      adv = bus.ser_req;
      #1;
      if (adv) ser_idx++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: each shift doubles the value modulo 2^W and adds the fill bit
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input int n,
                                              input int mode, input logic [63:0] bits);
    int v;
    int f;
    v = int'(d);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       f = 0;
        1:       f = 1;
        2:       f = int'(bits[i]);
        default: f = v / 128;
      endcase
      v = (v * 2 + f) % 256;
    end
    return v[W-1:0];
  endfunction

  // monitor: invariants every cycle, fill/countdown during shifts, result on done
  always @(negedge clk) begin
    if (!reset) begin
      chk("load_shift_excl", 32'(bus.reg_load & bus.reg_shift), 32'd0);
      chk("ready_vs_busy", 32'(bus.ready ^ bus.busy), 32'd1);
      chk("shifts_left_max", 32'(bus.shifts_left <= CW'(W)), 32'd1);
      if (bus.reg_load) shifts_seen = 0;
      if (bus.reg_shift) begin
        if (sb.size() != 0) begin
          logic f;
          case (sb[0].mode)
            0:       f = 1'b0;
            1:       f = 1'b1;
            2:       f = bus.serial_in;
            default: f = regv[W-1];
          endcase
          chk("d0_fill", 32'(bus.reg_d0), 32'(f));
          chk("shifts_left", 32'(bus.shifts_left), 32'(sb[0].cnt - shifts_seen));
        end
        shifts_seen++;
      end else begin
        chk("d0_idle", 32'(bus.reg_d0), 32'd0);
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 32'(regv), 32'(e.res));
          chk("latency", 32'(cyc), 32'(e.done_cyc));
          chk("shift_cycles", 32'(shifts_seen), 32'(e.cnt));
        end
      end
    end
  end

  // issue one request once ready; returns at the negedge of the LOAD cycle
  task automatic issue(input logic [W-1:0] d, input int cnt_req, input int mode,
                       input logic [63:0] bits, input bit track);
    int   n;
    int   eff;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", 32'(bus.ready), 32'd1);
      return;
    end
    ser_bits        = bits;
    ser_idx         = 0;
    bus.start       = 1'b1;
    bus.start_data  = d;
    bus.start_count = CW'(cnt_req);
    bus.start_mode  = 2'(mode);
    eff = (cnt_req > W) ? W : cnt_req;
    if (track) begin
      e.res      = ref_result(d, eff, mode, bits);
      e.done_cyc = cyc + eff + 2;
      e.cnt      = eff;
      e.mode     = mode;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start       = 1'b0;
    bus.start_data  = W'($urandom);
    bus.start_count = CW'($urandom);
    bus.start_mode  = 2'($urandom);
  endtask

  initial begin
    logic [W-1:0] held;
    int           n;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.start_data  = 8'h00;
    bus.start_count = {CW{1'b0}};
    bus.start_mode  = 2'd0;
`ifdef SHIFT_SEQUENCER_ABORT_EN
    bus.abort       = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_load", 32'(bus.reg_load), 32'd0);
    chk("rst_shift", 32'(bus.reg_shift), 32'd0);
    chk("rst_ser_req", 32'(bus.ser_req), 32'd0);
    chk("rst_d0", 32'(bus.reg_d0), 32'd0);
    chk("rst_load_data", 32'(bus.reg_load_data), 32'd0);
    chk("rst_shifts_left", 32'(bus.shifts_left), 32'd0);
    reset = 1'b0;

    issue(8'hA5, 3, 0, 64'd0, 1'b1);
    issue(8'h81, 1, 3, 64'd0, 1'b1);
    issue(8'h00, 12, 1, 64'd0, 1'b1);
    issue(8'h5A, 0, 0, 64'd0, 1'b1);
    issue(8'h00, 4, 2, 64'hD, 1'b1);

    // a start during SHIFT must not disturb the running operation
    issue(8'hC3, 5, 3, 64'd0, 1'b1);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.start_data  = 8'hFF;
    bus.start_count = CW'(1);
    bus.start_mode  = 2'd1;
    @(negedge clk);
    bus.start = 1'b0;

    // reset in the second SHIFT cycle: idle next cycle, register kept, no done
    issue(8'h96, 6, 0, 64'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    chk("midrst_shift", 32'(bus.reg_shift), 32'd0);
    chk("midrst_load", 32'(bus.reg_load), 32'd0);
    chk("midrst_shifts_left", 32'(bus.shifts_left), 32'd0);
    held  = regv;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_reg_held", 32'(regv), 32'(held));

`ifdef SHIFT_SEQUENCER_ABORT_EN
    issue(8'h3C, 4, 1, 64'd0, 1'b0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_pulse", 32'(bus.aborted), 32'd1);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    chk("abort_pulse_end", 32'(bus.aborted), 32'd0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_idle_noeffect", 32'(bus.aborted), 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
            {$urandom, $urandom}, 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that sequences one WIDTH-bit left-shifting register (load / shift / serial-in D0 interface) through a complete load-then-shift-N operation.
- Accepts a start request carrying operand, shift count and fill mode. Drives the register's load, load_data, shift and D0 inputs, and pulses done when the result is in the register.
- Sits between ALU control and the register file. It is the only driver of the register's control pins.

Parameters:
- WIDTH, 8, register width in bits.
- CNT_W, $clog2(WIDTH+1), shift-count field width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- start_data  in  WIDTH  operand to load.
- start_count  in  CNT_W  number of shifts requested.
- start_mode  in  2  fill mode: 0 ZERO, 1 ONE, 2 SERIAL, 3 ROTATE.
- serial_in  in  1  fill bit used in SERIAL mode.
- reg_q  in  WIDTH  current register contents (feedback for ROTATE).
- ready  out  1  high in IDLE only.
- busy  out  1  high in LOAD, SHIFT, DONE.
- done  out  1  one-cycle pulse in DONE.
- ser_req  out  1  high in each SHIFT cycle in SERIAL mode; the source advances serial_in after that edge.
- reg_load  out  1  to register load.
- reg_load_data  out  WIDTH  to register load_data.
- reg_shift  out  1  to register shift.
- reg_d0  out  1  to register D0.
- shifts_left  out  CNT_W  remaining shifts, for debug.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE.
- Reset (sync): state=IDLE.
  - ready=1.
  - busy=0, done=0, reg_load=0, reg_shift=0, ser_req=0, reg_d0=0.
  - reg_load_data=0, shifts_left=0.
- IDLE:
  - If start=1, latch data, mode and count. Count > WIDTH is clamped to WIDTH.
  - Next state is LOAD.
- LOAD, exactly one cycle:
  - reg_load=1, reg_load_data=latched data, reg_shift=0.
  - Next state is SHIFT if count>0, else DONE.
- SHIFT, one cycle per shift:
  - reg_shift=1, reg_load=0. shifts_left decrements each cycle.
  - Exit to DONE after the cycle in which shifts_left=1.
- reg_d0 during SHIFT:
  - ZERO: 0.
  - ONE: 1.
  - SERIAL: serial_in (combinational).
  - ROTATE: reg_q[WIDTH-1] (combinational).
- reg_d0 is 0 outside SHIFT.
- DONE, one cycle:
  - done=1. reg_q holds the final value during this cycle.
  - Next state is IDLE.
- Latency: for count N the sequence is start → LOAD → N × SHIFT → DONE. done is asserted N+2 cycles after the start edge.
- Control outputs are registered state decodes. reg_load and reg_shift are never both high.
- start while busy is ignored (not queued). start_* inputs are don't-care outside the accepting cycle.
- reset mid-operation: return to IDLE on the next edge.
  - reg_load and reg_shift drop immediately after that edge.
  - Register contents are left as-is.
  - done is not issued.

Optional Feature:
- Macro: SHIFT_SEQUENCER_ABORT_EN.
- Defined: add input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in LOAD or SHIFT: next state is IDLE, with aborted=1 for one cycle and no done.
  - abort in IDLE or DONE has no effect.
  - abort has priority over normal transitions.
- Undefined: the port and the logic are absent. An operation always runs to DONE.

Decomposition:
- Package shift_seq_pkg holds:
  - the fill-mode enum (MODE_ZERO, MODE_ONE, MODE_SERIAL, MODE_ROTATE);
  - the state enum (ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE);
  - default WIDTH.
- Sub-module shift_counter: loadable down-counter with clamp-on-load and a zero/one flag. The FSM in shift_sequencer uses it.

Test Plan:
- ZERO fill: start_data=0xA5, count=3, mode ZERO → load at cycle 1, shifts at cycles 2-4, done at cycle 5, reg_q=0x28.
- ROTATE: 0x81, count=1 → reg_d0=1 during the shift, reg_q=0x03, done at cycle 3.
- ONE fill with clamp: 0x00, count=12 → exactly 8 shift cycles, reg_q=0xFF, shifts_left never exceeds 8.
- Count=0: 0x5A → LOAD then DONE, no reg_shift, done at cycle 2, reg_q=0x5A.
- SERIAL: 0x00, count=4, serial_in stream 1,0,1,1 advanced on ser_req → reg_q=0x0B.
- Ignored start and reset:
  - start during SHIFT is ignored and does not change the result.
  - reset asserted in the 2nd SHIFT cycle → IDLE and ready=1 next cycle, no done.
  - With ABORT_EN, abort gives an aborted pulse and no done.
